// File: rtl/oled_spi_sink.sv
// rtl/oled_spi_sink.sv - SPI sink that decodes an OLED panel command/pixel byte stream
//
// Purpose: receives the SPI byte stream a host sends to an SSD1331-style OLED
// panel, splits it into command opcodes/parameters and pixel data, tracks the
// column/row window and write pointers, and reports each command byte and each
// completed pixel as a one-clk pulse in the clk domain.
//
// Ports:
//   clk          system clock, at least 4x oled_clk
//   resetn       asynchronous active-low reset
//   oled_csn     SPI chip select, active low (asynchronous to clk)
//   oled_clk     SPI clock, data sampled on its rising edge (asynchronous to clk)
//   oled_mosi    SPI data, MSB first
//   oled_dc      0 = command/parameter byte, 1 = pixel data byte
//   oled_resn    panel reset, active low, acts as a soft reset
//   cmd_valid    one-clk pulse per completed command-mode byte
//   cmd_byte     last command-mode byte
//   cmd_is_param 1 when cmd_byte is a parameter, 0 when it is an opcode
//   pix_valid    one-clk pulse per completed pixel
//   x, y         pixel column/row, valid with pix_valid
//   color        pixel value, first data byte in the MSBs

module oled_spi_sink #(
  parameter int C_color_bits = 8,
  parameter int C_x_size     = 96,
  parameter int C_y_size     = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    oled_csn,
  input  logic                    oled_clk,
  input  logic                    oled_mosi,
  input  logic                    oled_dc,
  input  logic                    oled_resn,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte,
  output logic                    cmd_is_param,
  output logic                    pix_valid,
  output logic [6:0]              x,
  output logic [5:0]              y,
  output logic [C_color_bits-1:0] color
);

  localparam logic [6:0] C_X_MAX = 7'(C_x_size - 1);
  localparam logic [5:0] C_Y_MAX = 6'(C_y_size - 1);
  localparam bit         C_WIDE  = (C_color_bits == 16);

  typedef enum logic {S_IDLE, S_PARAM} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Chip select and panel reset idle high so that a
  // released resetn does not look like an active transfer or a soft reset.
  // These are never touched by the soft reset, otherwise oled_resn would clear
  // its own synchroniser.
  // ---------------------------------------------------------------------------
  logic [1:0] r_csn_s, r_clk_s, r_mosi_s, r_dc_s, r_resn_s;
  logic       r_clk_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csn_s    <= 2'b11;
      r_clk_s    <= 2'b00;
      r_mosi_s   <= 2'b00;
      r_dc_s     <= 2'b00;
      r_resn_s   <= 2'b11;
      r_clk_prev <= 1'b0;
    end else begin
      r_csn_s    <= {r_csn_s[0], oled_csn};
      r_clk_s    <= {r_clk_s[0], oled_clk};
      r_mosi_s   <= {r_mosi_s[0], oled_mosi};
      r_dc_s     <= {r_dc_s[0], oled_dc};
      r_resn_s   <= {r_resn_s[0], oled_resn};
      r_clk_prev <= r_clk_s[1];
    end
  end

  logic w_csn, w_rise, w_soft_rst, w_dc;
  assign w_csn      = r_csn_s[1];
  assign w_rise     = r_clk_s[1] & ~r_clk_prev;
  assign w_soft_rst = ~r_resn_s[1];
  assign w_dc       = r_dc_s[1];

  // ---------------------------------------------------------------------------
  // Bit assembler. The 8th bit is not stored: the byte is presented
  // combinationally in the same clk as its edge so the decoded pulse appears
  // exactly one clk later.
  // ---------------------------------------------------------------------------
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else if (w_soft_rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else if (w_csn) begin
      r_bit_cnt <= 3'd0;
    end else if (w_rise) begin
      r_shift   <= {r_shift[5:0], r_mosi_s[1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  logic       w_byte_stb;
  logic [7:0] w_byte;
  assign w_byte_stb = w_rise & ~w_csn & (r_bit_cnt == 3'd7);
  assign w_byte     = {r_shift, r_mosi_s[1]};

  // ---------------------------------------------------------------------------
  // Command parser: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] f_param_count(input logic [7:0] op);
    case (op)
      8'h15, 8'h75:                                 f_param_count = 4'd2;
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B,
      8'h8C, 8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD,
      8'hB1, 8'hB3, 8'hBB, 8'hBE, 8'h26:            f_param_count = 4'd1;
      8'h21:                                        f_param_count = 4'd7;
      8'h22:                                        f_param_count = 4'd10;
      8'h23:                                        f_param_count = 4'd6;
      8'h24, 8'h25:                                 f_param_count = 4'd4;
      8'h27:                                        f_param_count = 4'd5;
      default:                                      f_param_count = 4'd0;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_n, w_n_nxt, w_pcnt;
  logic [7:0] r_op, w_op_nxt;

  assign w_pcnt = f_param_count(w_byte);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_n     <= 4'd0;
      r_op    <= 8'd0;
    end else if (w_soft_rst) begin
      r_state <= S_IDLE;
      r_n     <= 4'd0;
      r_op    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_op_nxt    = r_op;
    if (w_byte_stb) begin
      if (w_dc) begin
        // pixel data always ends any pending command
        w_state_nxt = S_IDLE;
        w_n_nxt     = 4'd0;
      end else if (r_state == S_IDLE) begin
        w_op_nxt    = w_byte;
        w_n_nxt     = w_pcnt;
        w_state_nxt = (w_pcnt != 4'd0) ? S_PARAM : S_IDLE;
      end else begin
        w_n_nxt     = r_n - 4'd1;
        w_state_nxt = (r_n == 4'd1) ? S_IDLE : S_PARAM;
      end
    end
  end

  logic w_cmd_stb, w_data_stb, w_is_param, w_win_cmd;
  logic w_col_s_we, w_col_e_we, w_row_s_we, w_row_e_we;

  always_comb begin
    w_cmd_stb  = w_byte_stb & ~w_dc;
    w_data_stb = w_byte_stb & w_dc;
    w_is_param = (r_state == S_PARAM);
    w_win_cmd  = w_cmd_stb & w_is_param;
    // r_n counts down, so 2 marks the first parameter and 1 the last
    w_col_s_we = w_win_cmd & (r_op == 8'h15) & (r_n == 4'd2);
    w_col_e_we = w_win_cmd & (r_op == 8'h15) & (r_n == 4'd1);
    w_row_s_we = w_win_cmd & (r_op == 8'h75) & (r_n == 4'd2);
    w_row_e_we = w_win_cmd & (r_op == 8'h75) & (r_n == 4'd1);
  end

  // ---------------------------------------------------------------------------
  // Pixel byte phase (only toggles in 16-bit mode)
  // ---------------------------------------------------------------------------
  logic r_phase, w_pix_done;
  assign w_pix_done = w_data_stb & (C_WIDE ? r_phase : 1'b1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase <= 1'b0;
    end else if (w_soft_rst || w_cmd_stb) begin
      r_phase <= 1'b0;
    end else if (w_data_stb && C_WIDE) begin
      r_phase <= ~r_phase;
    end
  end

  // ---------------------------------------------------------------------------
  // Window and write pointers
  // ---------------------------------------------------------------------------
  logic [6:0] r_col_start, r_col_end, r_col, w_col_nxt;
  logic [5:0] r_row_start, r_row_end, r_row, w_row_nxt, w_row_step;
  logic       w_col_at_end;

  always_comb begin
    w_col_at_end = (r_col == r_col_end);
    // an inverted window (start > end) walks to the panel edge, then wraps
    if (w_col_at_end || r_col == C_X_MAX) w_col_nxt = r_col_start;
    else                                  w_col_nxt = r_col + 7'd1;
    if (r_row == r_row_end || r_row == C_Y_MAX) w_row_step = r_row_start;
    else                                        w_row_step = r_row + 6'd1;
    w_row_nxt = w_col_at_end ? w_row_step : r_row;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col_start <= 7'd0;
      r_col_end   <= C_X_MAX;
      r_row_start <= 6'd0;
      r_row_end   <= C_Y_MAX;
      r_col       <= 7'd0;
      r_row       <= 6'd0;
    end else if (w_soft_rst) begin
      r_col_start <= 7'd0;
      r_col_end   <= C_X_MAX;
      r_row_start <= 6'd0;
      r_row_end   <= C_Y_MAX;
      r_col       <= 7'd0;
      r_row       <= 6'd0;
    end else begin
      if (w_col_s_we) r_col_start <= w_byte[6:0];
      if (w_col_e_we) begin
        r_col_end <= w_byte[6:0];
        r_col     <= r_col_start;
      end
      if (w_row_s_we) r_row_start <= w_byte[5:0];
      if (w_row_e_we) begin
        r_row_end <= w_byte[5:0];
        r_row     <= r_row_start;
      end
      // a command byte and a pixel completion never share a clk
      if (w_pix_done) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_valid    <= 1'b0;
      cmd_byte     <= 8'd0;
      cmd_is_param <= 1'b0;
      pix_valid    <= 1'b0;
      x            <= 7'd0;
      y            <= 6'd0;
    end else if (w_soft_rst) begin
      cmd_valid    <= 1'b0;
      cmd_byte     <= 8'd0;
      cmd_is_param <= 1'b0;
      pix_valid    <= 1'b0;
      x            <= 7'd0;
      y            <= 6'd0;
    end else begin
      cmd_valid <= w_cmd_stb;
      pix_valid <= w_pix_done;
      if (w_cmd_stb) begin
        cmd_byte     <= w_byte;
        cmd_is_param <= w_is_param;
      end
      if (w_pix_done) begin
        x <= r_col;
        y <= r_row;
      end
    end
  end

  generate
    if (C_WIDE) begin : g_color16
      logic [7:0] r_hi;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_hi  <= 8'd0;
          color <= '0;
        end else if (w_soft_rst) begin
          r_hi  <= 8'd0;
          color <= '0;
        end else begin
          if (w_data_stb && !r_phase) r_hi <= w_byte;
          if (w_pix_done) color <= {r_hi, w_byte};
        end
      end
    end else begin : g_color8
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          color <= '0;
        end else if (w_soft_rst) begin
          color <= '0;
        end else if (w_pix_done) begin
          color <= w_byte;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_oled_spi_sink.sv
// tb/tb_oled_spi_sink.sv - self-checking bench for oled_spi_sink (8-bit and 16-bit instances)

module tb_oled_spi_sink;

  logic clk = 1'b0;
  logic resetn, oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn;

  logic       d8_cmd_valid, d8_cmd_is_param, d8_pix_valid;
  logic [7:0] d8_cmd_byte;
  logic [6:0] d8_x;
  logic [5:0] d8_y;
  logic [7:0] d8_color;

  logic        d16_cmd_valid, d16_cmd_is_param, d16_pix_valid;
  logic [7:0]  d16_cmd_byte;
  logic [6:0]  d16_x;
  logic [5:0]  d16_y;
  logic [15:0] d16_color;

  always #5 clk = ~clk;

  oled_spi_sink #(.C_color_bits(8), .C_x_size(96), .C_y_size(64)) u_dut8 (
    .clk(clk), .resetn(resetn), .oled_csn(oled_csn), .oled_clk(oled_clk),
    .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_resn(oled_resn),
    .cmd_valid(d8_cmd_valid), .cmd_byte(d8_cmd_byte), .cmd_is_param(d8_cmd_is_param),
    .pix_valid(d8_pix_valid), .x(d8_x), .y(d8_y), .color(d8_color));

  oled_spi_sink #(.C_color_bits(16), .C_x_size(96), .C_y_size(64)) u_dut16 (
    .clk(clk), .resetn(resetn), .oled_csn(oled_csn), .oled_clk(oled_clk),
    .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_resn(oled_resn),
    .cmd_valid(d16_cmd_valid), .cmd_byte(d16_cmd_byte), .cmd_is_param(d16_cmd_is_param),
    .pix_valid(d16_pix_valid), .x(d16_x), .y(d16_y), .color(d16_color));

  typedef struct {
    logic        is_pix;
    logic        par;
    logic [7:0]  b;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] color;
    int          cyc;
  } ev_t;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    logic       is_pix;
    logic       par;
    logic [6:0] ex;
    logic [5:0] ey;
    logic [7:0] eval;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int r8_cyc   = 0;
  int n_both   = 0;
  int n_ev8    = 0;

  ev_t q_got[2][$];
  ev_t q_exp[2][$];
  ev_t mon_e;
  ev_t last8;
  logic [15:0] last_color16 = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Output monitor, sampled on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if ((d8_cmd_valid && d8_pix_valid) || (d16_cmd_valid && d16_pix_valid)) n_both++;
    mon_e = '{is_pix: 1'b0, par: 1'b0, b: 8'h0, x: 7'h0, y: 6'h0, color: 16'h0, cyc: cyc};
    if (d8_cmd_valid) begin
      mon_e.is_pix = 1'b0; mon_e.par = d8_cmd_is_param; mon_e.b = d8_cmd_byte;
      q_got[0].push_back(mon_e); last8 = mon_e; n_ev8++;
    end
    if (d8_pix_valid) begin
      mon_e.is_pix = 1'b1; mon_e.x = d8_x; mon_e.y = d8_y; mon_e.color = {8'h0, d8_color};
      q_got[0].push_back(mon_e); last8 = mon_e; n_ev8++;
    end
    mon_e = '{is_pix: 1'b0, par: 1'b0, b: 8'h0, x: 7'h0, y: 6'h0, color: 16'h0, cyc: cyc};
    if (d16_cmd_valid) begin
      mon_e.is_pix = 1'b0; mon_e.par = d16_cmd_is_param; mon_e.b = d16_cmd_byte;
      q_got[1].push_back(mon_e);
    end
    if (d16_pix_valid) begin
      mon_e.is_pix = 1'b1; mon_e.x = d16_x; mon_e.y = d16_y; mon_e.color = d16_color;
      q_got[1].push_back(mon_e); last_color16 = d16_color;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: panel byte-stream semantics for both colour depths
  // ---------------------------------------------------------------------------
  int         m_n, m_idx;
  logic [7:0] m_op, m_hi;
  logic [6:0] m_cs, m_ce;
  logic [5:0] m_rs, m_re;
  logic [6:0] m_col[2];
  logic [5:0] m_row[2];
  bit         m_phase;

  function automatic int nparams(input logic [7:0] op);
    case (op)
      8'h15, 8'h75: return 2;
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0, 8'hA1,
      8'hA2, 8'hA8, 8'hAD, 8'hB1, 8'hB3, 8'hBB, 8'hBE, 8'h26: return 1;
      8'h21: return 7;
      8'h22: return 10;
      8'h23: return 6;
      8'h24, 8'h25: return 4;
      8'h27: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_idx = 0; m_op = 8'h0; m_hi = 8'h0; m_phase = 1'b0;
    m_cs = 7'd0; m_ce = 7'd95; m_rs = 6'd0; m_re = 6'd63;
    for (int d = 0; d < 2; d++) begin m_col[d] = 7'd0; m_row[d] = 6'd0; end
  endtask

  task automatic model_pixel(input int d, input logic [15:0] c);
    ev_t e;
    e = '{is_pix: 1'b1, par: 1'b0, b: 8'h0, x: m_col[d], y: m_row[d], color: c, cyc: 0};
    q_exp[d].push_back(e);
    if (m_col[d] == m_ce) begin
      m_col[d] = m_cs;
      if (m_row[d] == m_re || m_row[d] == 6'd63) m_row[d] = m_rs;
      else m_row[d] = m_row[d] + 6'd1;
    end else if (m_col[d] == 7'd95) begin
      m_col[d] = m_cs;
    end else begin
      m_col[d] = m_col[d] + 7'd1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    ev_t e;
    if (!dc) begin
      e = '{is_pix: 1'b0, par: (m_n > 0), b: b, x: 7'h0, y: 6'h0, color: 16'h0, cyc: 0};
      q_exp[0].push_back(e);
      q_exp[1].push_back(e);
      if (m_n == 0) begin
        m_op = b; m_n = nparams(b); m_idx = 0;
      end else begin
        if (m_op == 8'h15) begin if (m_idx == 0) m_cs = b[6:0]; else m_ce = b[6:0]; end
        if (m_op == 8'h75) begin if (m_idx == 0) m_rs = b[5:0]; else m_re = b[5:0]; end
        m_idx++; m_n--;
        if (m_n == 0 && m_op == 8'h15) begin m_col[0] = m_cs; m_col[1] = m_cs; end
        if (m_n == 0 && m_op == 8'h75) begin m_row[0] = m_rs; m_row[1] = m_rs; end
      end
      m_phase = 1'b0;
    end else begin
      m_n = 0;
      model_pixel(0, {8'h0, b});
      if (!m_phase) begin m_hi = b; m_phase = 1'b1; end
      else begin model_pixel(1, {m_hi, b}); m_phase = 1'b0; end
    end
  endtask

  // ---------------------------------------------------------------------------
  // SPI driver and comparison helpers
  // ---------------------------------------------------------------------------
  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    oled_csn = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      oled_clk = 1'b0; oled_mosi = b[7-i]; oled_dc = dc;
      tick(4);
      oled_clk = 1'b1;
      if (i == 7) r8_cyc = cyc;
      tick(4);
    end
    oled_clk = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    ev_t g, e;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_count", tag, d), q_got[d].size(), q_exp[d].size());
      while (q_got[d].size() > 0 && q_exp[d].size() > 0) begin
        g = q_got[d].pop_front();
        e = q_exp[d].pop_front();
        chk($sformatf("%s_d%0d_kind", tag, d), g.is_pix, e.is_pix);
        if (e.is_pix) begin
          chk($sformatf("%s_d%0d_x", tag, d), g.x, e.x);
          chk($sformatf("%s_d%0d_y", tag, d), g.y, e.y);
          chk($sformatf("%s_d%0d_color", tag, d), g.color, e.color);
        end else begin
          chk($sformatf("%s_d%0d_cmd_byte", tag, d), g.b, e.b);
          chk($sformatf("%s_d%0d_is_param", tag, d), g.par, e.par);
        end
        chk($sformatf("%s_d%0d_latency", tag, d), g.cyc - r8_cyc, 3);
      end
      q_got[d].delete();
      q_exp[d].delete();
    end
    chk($sformatf("%s_cmd_pix_exclusive", tag), n_both, 0);
  endtask

  task automatic send_and_check(input logic [7:0] b, input logic dc, input string tag);
    model_byte(b, dc);
    send_bits(b, dc, 8);
    tick(6);
    compare_model(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_d8_outs"}, {d8_cmd_valid, d8_cmd_byte, d8_cmd_is_param, d8_pix_valid,
                            d8_x, d8_y, d8_color}, 32'h0);
    chk({tag, "_d16_outs"}, {d16_cmd_valid, d16_cmd_byte, d16_cmd_is_param, d16_pix_valid}, 32'h0);
    chk({tag, "_d16_xyc"}, {d16_x, d16_y, d16_color}, 32'h0);
  endtask

  task automatic hard_reset(input string tag);
    resetn = 1'b0;
    tick(3);
    check_outputs_zero(tag);
    resetn = 1'b1;
    tick(3);
    model_reset();
    q_got[0].delete(); q_got[1].delete();
    q_exp[0].delete(); q_exp[1].delete();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs[15];
  int   n_before;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; oled_csn = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0;
    oled_dc = 1'b0; oled_resn = 1'b1;

    vecs[0]  = '{1'b0, 8'hA0, 1'b0, 1'b0, 7'd0,  6'd0, 8'hA0};
    vecs[1]  = '{1'b0, 8'h15, 1'b0, 1'b1, 7'd0,  6'd0, 8'h15};
    vecs[2]  = '{1'b1, 8'h11, 1'b1, 1'b0, 7'd0,  6'd0, 8'h11};
    vecs[3]  = '{1'b0, 8'h15, 1'b0, 1'b0, 7'd0,  6'd0, 8'h15};
    vecs[4]  = '{1'b0, 8'h10, 1'b0, 1'b1, 7'd0,  6'd0, 8'h10};
    vecs[5]  = '{1'b0, 8'h12, 1'b0, 1'b1, 7'd0,  6'd0, 8'h12};
    vecs[6]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 7'd16, 6'd0, 8'hAA};
    vecs[7]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 7'd17, 6'd0, 8'hAA};
    vecs[8]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 7'd18, 6'd0, 8'hAA};
    vecs[9]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 7'd16, 6'd1, 8'hAA};
    vecs[10] = '{1'b0, 8'h75, 1'b0, 1'b0, 7'd0,  6'd0, 8'h75};
    vecs[11] = '{1'b1, 8'h5C, 1'b1, 1'b0, 7'd17, 6'd1, 8'h5C};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0,  6'd0, 8'h00};
    vecs[13] = '{1'b1, 8'h77, 1'b1, 1'b0, 7'd18, 6'd1, 8'h77};
    vecs[14] = '{1'b1, 8'h78, 1'b1, 1'b0, 7'd16, 6'd2, 8'h78};

    hard_reset("reset");

    // table-driven sequence on the 8-bit instance; the model checks both
    for (int i = 0; i < 15; i++) begin
      n_before = n_ev8;
      model_byte(vecs[i].data, vecs[i].dc);
      send_bits(vecs[i].data, vecs[i].dc, 8);
      tick(6);
      chk($sformatf("vec%0d_events", i), n_ev8 - n_before, 1);
      chk($sformatf("vec%0d_kind", i), last8.is_pix, vecs[i].is_pix);
      if (vecs[i].is_pix) begin
        chk($sformatf("vec%0d_xy", i), {last8.x, last8.y}, {vecs[i].ex, vecs[i].ey});
        chk($sformatf("vec%0d_color", i), last8.color, {8'h0, vecs[i].eval});
      end else begin
        chk($sformatf("vec%0d_cmd", i), {last8.par, last8.b}, {vecs[i].par, vecs[i].eval});
      end
      compare_model($sformatf("vec%0d", i));
    end

    // 16-bit pixel assembly
    send_and_check(8'h00, 1'b0, "c16_cmd");
    send_and_check(8'hF8, 1'b1, "c16_hi");
    send_and_check(8'h1F, 1'b1, "c16_lo");
    chk("c16_color", last_color16, 16'hF81F);

    // partial byte discarded by chip select
    hard_reset("reset2");
    send_bits(8'hFF, 1'b0, 5);
    oled_csn = 1'b1;
    tick(4);
    send_and_check(8'hE3, 1'b1, "partial");
    chk("partial_pix", {last8.is_pix, last8.x, last8.y, last8.color[7:0]}, {1'b1, 7'd0, 6'd0, 8'hE3});

    // move the pointers to (95,63) under the default window, then wrap
    hard_reset("reset3");
    send_and_check(8'h75, 1'b0, "corner_a"); send_and_check(8'h3F, 1'b0, "corner_b");
    send_and_check(8'h3F, 1'b0, "corner_c"); send_and_check(8'h75, 1'b0, "corner_d");
    send_and_check(8'h00, 1'b0, "corner_e"); send_and_check(8'hAB, 1'b1, "corner_f");
    send_and_check(8'h15, 1'b0, "corner_g"); send_and_check(8'h5F, 1'b0, "corner_h");
    send_and_check(8'h5F, 1'b0, "corner_i"); send_and_check(8'h15, 1'b0, "corner_j");
    send_and_check(8'h00, 1'b0, "corner_k");
    send_and_check(8'hCD, 1'b1, "corner_l");
    chk("corner_last_xy", {last8.x, last8.y}, {7'd95, 6'd63});
    send_and_check(8'hEF, 1'b1, "corner_m");
    chk("corner_wrap_xy", {last8.x, last8.y}, {7'd0, 6'd0});

    // resetn pulsed mid-byte, chip select stays low
    send_bits(8'hC3, 1'b1, 4);
    hard_reset("midbyte");
    send_and_check(8'h3C, 1'b1, "after_reset");
    chk("after_reset_pix", {last8.x, last8.y, last8.color[7:0]}, {7'd0, 6'd0, 8'h3C});

    // soft reset through oled_resn
    send_and_check(8'h15, 1'b0, "soft_a"); send_and_check(8'h05, 1'b0, "soft_b");
    send_and_check(8'h07, 1'b0, "soft_c"); send_and_check(8'h21, 1'b1, "soft_d");
    chk("soft_pre_xy", {last8.x, last8.y}, {7'd5, 6'd0});
    oled_resn = 1'b0;
    tick(5);
    check_outputs_zero("soft");
    oled_resn = 1'b1;
    tick(4);
    model_reset();
    send_and_check(8'h42, 1'b1, "soft_after");
    chk("soft_after_xy", {last8.x, last8.y}, {7'd0, 6'd0});

    // randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      logic [7:0] b;
      logic       dc;
      int         r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        case ($urandom_range(0, 7))
          0: b = 8'h15; 1: b = 8'h75; 2: b = 8'hA0; 3: b = 8'h21;
          4: b = 8'h27; 5: b = 8'hAF; 6: b = 8'h26; default: b = 8'h22;
        endcase
        dc = 1'b0;
      end else if (r <= 4) begin
        b = 8'($urandom_range(0, 255)); dc = 1'b0;
      end else begin
        b = 8'($urandom_range(0, 255)); dc = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        send_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(1, 7));
        oled_csn = 1'b1;
        tick(3);
      end
      send_and_check(b, dc, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        oled_csn = 1'b1;
        tick($urandom_range(2, 6));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
